// File: rtl/demux_pkg.sv
// Shared constants for the demux and its decoder.
// The parameter defaults live here so that a mux/demux pair can agree on them.
package demux_pkg;

   localparam int unsigned WORD_DEFAULT = 8;
   localparam int unsigned MUX_DEFAULT  = 2;

endpackage

// File: rtl/demux_if.sv
// Data/select/line bundle for the demux.
// The master drives the routed bit and its index; the slave returns the registered lines.
interface demux_if
   import demux_pkg::*;
#(
   parameter int unsigned WORD = WORD_DEFAULT,
   parameter int unsigned MUX  = MUX_DEFAULT
) ();

   logic            i;
   logic [MUX-1:0]  select;
   logic [WORD-1:0] line;

   modport master (output i, output select, input line);
   modport slave  (input i, input select, output line);

endinterface

// File: rtl/demux_decode.sv
// Combinational one-hot decoder: result[select] = i, every other bit 0.
// Indices at or beyond WORD never match, so out-of-range selects give all zeros.
module demux_decode
   import demux_pkg::*;
#(
   parameter int unsigned WORD = WORD_DEFAULT,
   parameter int unsigned MUX  = MUX_DEFAULT
) (
   input  logic [MUX-1:0]  select,
   input  logic            i,
   output logic [WORD-1:0] result
);

   for (genvar k = 0; k < WORD; k++) begin : g_bit
      // Compare at full width so no index ever wraps onto a lower line.
      assign result[k] = i & (32'(select) == 32'(k));
   end

endmodule

// File: rtl/demux.sv
// Registered 1-to-WORD demultiplexer: line loads the decoded select/i on every rising edge.
// Asynchronous active-low reset clears line immediately.
module demux
   import demux_pkg::*;
#(
   parameter int unsigned WORD = WORD_DEFAULT,
   parameter int unsigned MUX  = MUX_DEFAULT
) (
   input logic     clk,
   input logic     reset,
   demux_if.slave  bus
);

   logic [WORD-1:0] line_d;
   logic [WORD-1:0] line_q;

   demux_decode #(
      .WORD (WORD),
      .MUX  (MUX)
   ) u_decode (
      .select (bus.select),
      .i      (bus.i),
      .result (line_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign bus.line = line_q;

endmodule

// File: tb/tb_demux.sv
// Bench for demux: a default build (WORD=8, MUX=2) and a narrow build (WORD=4, MUX=3)
// run side by side against a routing model plus directed literal checks.
module tb_demux;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   demux_if #(.WORD(8), .MUX(2)) bus8 ();
   demux_if #(.WORD(4), .MUX(3)) bus4 ();

   demux #(.WORD(8), .MUX(2)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
   demux #(.WORD(4), .MUX(3)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

   always #5 clk = ~clk;

   // Expected line: a single 1 at position s when the bit is set and s fits.
   function automatic logic [31:0] route(input logic b, input int unsigned s,
                                         input int unsigned w);
      if (b && s < w) return 32'd1 << s;
      return 32'd0;
   endfunction

   logic [7:0] exp8 = '0;
   logic [3:0] exp4 = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp8 <= '0;
         exp4 <= '0;
      end else begin
         exp8 <= 8'(route(bus8.i, 32'(bus8.select), 8));
         exp4 <= 4'(route(bus4.i, 32'(bus4.select), 4));
      end
   end

   always @(negedge clk) begin
      n_cmp++;
      if (bus8.line !== exp8) begin
         n_bad++;
         $display("FAIL model8 t=%0t actual=%h required=%h", $time, bus8.line, exp8);
      end
      n_cmp++;
      if (bus4.line !== exp4) begin
         n_bad++;
         $display("FAIL model4 t=%0t actual=%h required=%h", $time, bus4.line, exp4);
      end
   end

   task automatic check8(input string name, input logic [7:0] req);
      n_cmp++;
      if (bus8.line !== req) begin
         n_bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, bus8.line, req);
      end
   endtask

   task automatic check4(input string name, input logic [3:0] req);
      n_cmp++;
      if (bus4.line !== req) begin
         n_bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, bus4.line, req);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus8.i      = 1'b1;
      bus8.select = 2'd0;
      bus4.i      = 1'b1;
      bus4.select = 3'd5;

      // Reset held with i=1, select=0: no edge has happened yet.
      #3;
      check8("reset_no_edge", 8'h00);
      check4("reset_no_edge_w4", 4'h0);
      reset = 1'b1;
      step();
      check8("first_edge", 8'h01);
      check4("sel5_w4", 4'h0);

      // Walk select 0..3 with i=1; each value shows one edge later.
      bus8.select = 2'd1;
      #1 check8("latency_hold", 8'h01);
      step();
      check8("sel1", 8'h02);
      bus8.select = 2'd2;
      step();
      check8("sel2", 8'h04);
      bus8.select = 2'd3;
      step();
      check8("sel3", 8'h08);

      bus8.i      = 1'b0;
      bus8.select = 2'd2;
      step();
      check8("i0_sel2", 8'h00);

      // Mid-cycle select change must wait for the next edge.
      bus8.i      = 1'b1;
      bus8.select = 2'd1;
      step();
      check8("pre_mid", 8'h02);
      #4 bus8.select = 2'd2;
      #1 check8("mid_change_hold", 8'h02);
      step();
      check8("mid_change_edge", 8'h04);

      // Reset pulse between edges while line = 04.
      #2 reset = 1'b0;
      #1 check8("reset_pulse", 8'h00);
      check4("reset_pulse_w4", 4'h0);
      #1 reset = 1'b1;
      #1 check8("after_release", 8'h00);
      step();
      check8("release_edge", 8'h04);

      // Narrow build: in-range, just out of range (no modulo), and top index.
      bus4.select = 3'd2;
      step();
      check4("w4_sel2", 4'h4);
      bus4.select = 3'd4;
      step();
      check4("w4_sel4_nowrap", 4'h0);
      bus4.select = 3'd3;
      step();
      check4("w4_sel3", 4'h8);
      bus4.select = 3'd7;
      step();
      check4("w4_sel7", 4'h0);
      bus4.select = 3'd5;
      step();
      check4("w4_sel5", 4'h0);

      // Random traffic, checked by the model on every cycle.
      for (int n = 0; n < 200; n++) begin
         bus8.i      = 1'($urandom_range(0, 1));
         bus8.select = 2'($urandom_range(0, 3));
         bus4.i      = 1'($urandom_range(0, 1));
         bus4.select = 3'($urandom_range(0, 7));
         step();
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 The block SHALL have parameter WORD, default 8, giving the output line count and the width of line.
REQ-002 The block SHALL have parameter MUX, default 2, giving the select width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i, input, 1 bit: the data bit to route.
REQ-006 The block SHALL have port select, input, MUX bits: the unsigned index of the destination line.
REQ-007 The block SHALL have port line, output, WORD bits: the routed data, one bit per destination.

Function
REQ-008 On every rising clk edge with reset high, line SHALL load a value with bit[select] = i and all other bits 0.
REQ-009 Latency SHALL be one clock: a select or i change becomes visible on line after the next rising edge. line SHALL be driven only from registers, never combinationally from inputs.
REQ-010 When i = 0, line SHALL load all zeros, whatever select is.
REQ-011 At most one bit of line SHALL be 1 at any time (one-hot or zero).
REQ-012 If select >= WORD, line SHALL load all zeros; no wrap-around or modulo indexing is allowed.
REQ-013 If WORD > 2^MUX, bits at or above 2^MUX are unreachable and SHALL stay 0.
REQ-014 Changes in i or select between clock edges SHALL NOT affect line until the next rising edge.
REQ-015 Unknown (X) on select while i = 1 is outside the contract; the design need not resolve it.

Reset
REQ-016 While reset is low, line SHALL be all zeros immediately, without waiting for a clock edge.
REQ-017 A reset asserted mid-operation SHALL clear line at once, discarding the routed bit.
REQ-018 After reset deasserts, the first rising edge SHALL load line per REQ-008.

Structure
REQ-019 The default values of WORD and MUX SHALL be constants in a shared package; the block's parameters default to them.
REQ-020 The decode SHALL be a combinational one-hot decoder feeding a WORD-bit register bank.
REQ-021 The decoder SHALL be a separate sub-module, demux_decode, with ports select, i and a WORD-bit result, so the mux/demux pair can reuse it.

Verification
REQ-022 The bench SHALL cover reset low with i = 1 and select = 0: line = 8'h00 with no clock edge; after reset releases, the first edge gives line = 8'h01.
REQ-023 The bench SHALL cover i = 1 stepping select 0, 1, 2, 3 on successive edges: line = 8'h01, 8'h02, 8'h04, 8'h08, each appearing one edge after the select change.
REQ-024 The bench SHALL cover i = 0 with select = 2: line = 8'h00 after the next edge.
REQ-025 The bench SHALL cover changing select mid-cycle from 1 to 2: line stays 8'h02 until the next rising edge, then becomes 8'h04.
REQ-026 The bench SHALL cover reset pulsed low between edges while line = 8'h04: line = 8'h00 immediately and stays 0 until the first edge after release.
REQ-027 The bench SHALL cover a build with WORD = 4 and MUX = 3, select = 5, i = 1: line = 4'h0.
